// File: rtl/snoop_resp_collector.sv
// Merges ACE snoop responses (CR) and snoop data (CD) from all snooped masters into one
// response, buffering the selected master's 4-beat line and streaming it after data_rdy.
module snoop_resp_collector #(
  parameter int DATA_SIZE   = 128,
  parameter int NUM_MASTERS = 8
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          snoop_start,
  input  logic [NUM_MASTERS-1:0]        snoop_mask,
  input  logic [NUM_MASTERS-1:0]        CRVALID,
  output logic [NUM_MASTERS-1:0]        CRREADY,
  input  logic [5*NUM_MASTERS-1:0]      CRRESP,
  input  logic [NUM_MASTERS-1:0]        CDVALID,
  output logic [NUM_MASTERS-1:0]        CDREADY,
  input  logic [DATA_SIZE*NUM_MASTERS-1:0] CDDATA,
  input  logic [NUM_MASTERS-1:0]        CDLAST,
  output logic [DATA_SIZE-1:0]          cache_line_out,
  output logic [3:0]                    crresp_out,
  output logic                          data_rdy,
  output logic                          no_data,
  output logic                          busy
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [2:0] {
    IDLE, CR_COLLECT, CD_COLLECT, ANNOUNCE, STREAM, NODATA
  } state_t;

  // Handshake: a CR/CD transfer for master i happens on a rising edge where VALID[i] and
  // READY[i] are both high; READY is driven only from registered pend bits, never from VALID.
  state_t                            state_q, state_d;
  logic [NUM_MASTERS-1:0]            cr_pend_q, cr_pend_d;
  logic [NUM_MASTERS-1:0]            cd_pend_q, cd_pend_d;
  logic                              shared_q, shared_d;
  logic                              dirty_q, dirty_d;
  logic                              err_q, err_d;
  logic                              sel_valid_q, sel_valid_d;
  logic [IDX_W-1:0]                  sel_idx_q, sel_idx_d;
  logic [1:0]                        beat_cnt_q, beat_cnt_d;
  logic                              full_q, full_d;
  logic [1:0]                        out_cnt_q, out_cnt_d;
  logic [3:0][DATA_SIZE-1:0]         buf_q, buf_d;

  logic [NUM_MASTERS-1:0]            cr_hs, cd_hs, dt_hs;
  logic [IDX_W-1:0]                  low_idx;
  logic [DATA_SIZE-1:0]              sel_data;
  logic [NUM_MASTERS-1:0]            unused_was_unique;

  always_comb begin
    state_d     = state_q;
    cr_pend_d   = cr_pend_q;
    cd_pend_d   = cd_pend_q;
    shared_d    = shared_q;
    dirty_d     = dirty_q;
    err_d       = err_q;
    sel_valid_d = sel_valid_q;
    sel_idx_d   = sel_idx_q;
    beat_cnt_d  = beat_cnt_q;
    full_d      = full_q;
    out_cnt_d   = out_cnt_q;
    buf_d       = buf_q;

    cr_hs    = CRVALID & cr_pend_q;
    cd_hs    = CDVALID & cd_pend_q;
    sel_data = CDDATA[int'(sel_idx_q)*DATA_SIZE +: DATA_SIZE];
    dt_hs    = '0;
    low_idx  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      unused_was_unique[i] = CRRESP[5*i+4];
      dt_hs[i]             = cr_hs[i] & CRRESP[5*i];
    end
    for (int i = NUM_MASTERS-1; i >= 0; i--) begin
      if (dt_hs[i]) low_idx = IDX_W'(i);
    end

    case (state_q)
      IDLE: begin
        if (snoop_start) begin
          cr_pend_d   = snoop_mask;
          cd_pend_d   = '0;
          shared_d    = 1'b0;
          dirty_d     = 1'b0;
          err_d       = 1'b0;
          sel_valid_d = 1'b0;
          sel_idx_d   = '0;
          beat_cnt_d  = '0;
          full_d      = 1'b0;
          buf_d       = '0;
          state_d     = (|snoop_mask) ? CR_COLLECT : NODATA;
        end
      end
      CR_COLLECT: begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (cr_hs[i]) begin
            cr_pend_d[i] = 1'b0;
            shared_d     = shared_d | CRRESP[5*i+3];
            dirty_d      = dirty_d  | CRRESP[5*i+2];
            err_d        = err_d    | CRRESP[5*i+1];
            if (CRRESP[5*i]) cd_pend_d[i] = 1'b1;
          end
        end
        if (!sel_valid_q && (|dt_hs)) begin
          sel_valid_d = 1'b1;
          sel_idx_d   = low_idx;
        end
        if (cr_pend_d == '0) state_d = (|cd_pend_d) ? CD_COLLECT : NODATA;
      end
      CD_COLLECT: begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (cd_hs[i] && CDLAST[i]) cd_pend_d[i] = 1'b0;
        end
        // Only the selected master fills the line; anything past beat 3 is an error.
        if (cd_hs[sel_idx_q]) begin
          if (full_q) begin
            err_d = 1'b1;
          end else begin
            buf_d[beat_cnt_q] = sel_data;
            beat_cnt_d        = beat_cnt_q + 2'd1;
            if (beat_cnt_q == 2'd3) full_d = 1'b1;
            if (CDLAST[sel_idx_q] && beat_cnt_q != 2'd3) err_d = 1'b1;
          end
        end
        if (cd_pend_d == '0) state_d = ANNOUNCE;
      end
      ANNOUNCE: begin
        out_cnt_d = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        out_cnt_d = out_cnt_q + 2'd1;
        if (out_cnt_q == 2'd3) state_d = IDLE;
      end
      NODATA:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cr_pend_q   <= '0;
      cd_pend_q   <= '0;
      shared_q    <= 1'b0;
      dirty_q     <= 1'b0;
      err_q       <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_idx_q   <= '0;
      beat_cnt_q  <= '0;
      full_q      <= 1'b0;
      out_cnt_q   <= '0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      cr_pend_q   <= cr_pend_d;
      cd_pend_q   <= cd_pend_d;
      shared_q    <= shared_d;
      dirty_q     <= dirty_d;
      err_q       <= err_d;
      sel_valid_q <= sel_valid_d;
      sel_idx_q   <= sel_idx_d;
      beat_cnt_q  <= beat_cnt_d;
      full_q      <= full_d;
      out_cnt_q   <= out_cnt_d;
      buf_q       <= buf_d;
    end
  end

  assign CRREADY        = (state_q == CR_COLLECT) ? cr_pend_q : '0;
  assign CDREADY        = (state_q == CD_COLLECT) ? cd_pend_q : '0;
  assign cache_line_out = (state_q == STREAM) ? buf_q[out_cnt_q] : '0;
  assign crresp_out     = {shared_q, dirty_q, err_q, 1'b0};
  assign data_rdy       = (state_q == ANNOUNCE);
  assign no_data        = (state_q == NODATA);
  assign busy           = (state_q != IDLE);

endmodule

// File: doc/snoop_resp_collector.md
# snoop_resp_collector

Collects ACE snoop responses (CR channel) and snoop data (CD channel) from every snooped master after an AC broadcast and reduces them to one merged response. If any master returned data, the block buffers the full 4-beat cache line, pulses `data_rdy`, then streams the beats; if none did, it pulses `no_data`. It sits directly upstream of the initiating-master response stage, which consumes `cache_line_out`, `crresp_out`, `data_rdy` and `no_data`.

## Interface
- `DATA_SIZE`, 128, width of one CD beat and of `cache_line_out`
- `NUM_MASTERS`, 8, number of snoopable masters; bit i of every vector is master i
- Line length is fixed at 4 beats.

- `ACLK` in 1: single clock, all logic on rising edge
- `ARESET` in 1: reset, synchronous, active-high
- `snoop_start` in 1: one-cycle pulse when the AC broadcast is issued
- `snoop_mask` in NUM_MASTERS: masters snooped; sampled with `snoop_start`
- `CRVALID` in NUM_MASTERS; `CRREADY` out NUM_MASTERS
- `CRRESP` in 5*NUM_MASTERS: per master {WasUnique[4], IsShared[3], PassDirty[2], Error[1], DataTransfer[0]}
- `CDVALID` in NUM_MASTERS; `CDREADY` out NUM_MASTERS
- `CDDATA` in DATA_SIZE*NUM_MASTERS; `CDLAST` in NUM_MASTERS
- `cache_line_out` out DATA_SIZE: streamed line beat
- `crresp_out` out 4: merged response {IsShared, PassDirty, RESP[1:0]}
- `data_rdy` out 1: one-cycle pulse, line follows
- `no_data` out 1: one-cycle pulse, no master supplied data
- `busy` out 1: high whenever the FSM is not IDLE

## Operation
- FSM states: IDLE, CR_COLLECT, CD_COLLECT, ANNOUNCE, STREAM, NODATA.
- IDLE: on `snoop_start`, load `cr_pend`=`snoop_mask` and clear the accumulators (shared, dirty, err, sel_valid, cd_pend, buffer). Go to CR_COLLECT, or to NODATA if the mask is zero. `snoop_start` outside IDLE is ignored.
- CR_COLLECT: `CRREADY` = `cr_pend`. For each handshake i:
  - clear `cr_pend[i]`
  - OR bits 3, 2 and 1 into the shared, dirty and err accumulators
  - if DataTransfer is set, set `cd_pend[i]`
  - the first master with DataTransfer becomes the selected source; among simultaneous handshakes, the lowest index wins.
- Leave CR_COLLECT when `cr_pend` becomes zero, including bits cleared in the same cycle. Go to CD_COLLECT if `cd_pend` is non-zero, else NODATA.
- CD_COLLECT: `CDREADY` = `cd_pend`.
  - Beats from the selected master are written to buffer[beat_cnt], and the 2-bit `beat_cnt` increments.
  - Beats from other masters are accepted and discarded.
  - `CDLAST` on a handshake clears that master's `cd_pend` bit.
  - If the selected master's `CDLAST` arrives with `beat_cnt`≠3, or a 5th beat arrives without `CDLAST`, set err. Extra beats are discarded; missing beats stay 0.
  - Go to ANNOUNCE when `cd_pend` becomes zero.
- ANNOUNCE: `data_rdy`=1 for one cycle. Go to STREAM with `out_cnt`=0.
- STREAM: `cache_line_out` = buffer[`out_cnt`] for 4 consecutive cycles (0,1,2,3) with no backpressure, then IDLE.
- NODATA: `no_data`=1 for one cycle, then IDLE.
- `crresp_out` = {shared, dirty, err ? 2'b10 : 2'b00}. It is valid from ANNOUNCE/NODATA until the next `snoop_start`, and 0 before the first transaction.
- `CRREADY`/`CDREADY` are 0 outside their states. Data presented early on CD waits until CD_COLLECT.

## Timing
- Reset: state IDLE. All outputs are 0: `CRREADY`, `CDREADY`, `cache_line_out`, `crresp_out`, `data_rdy`, `no_data`, `busy`. Counters and accumulators are cleared and the buffer is zeroed.
- Reset mid-operation aborts the transaction. Partially collected data is discarded and no pulse is issued.
- All outputs are Moore: decoded from registered state/counters. `CRREADY`/`CDREADY` are decoded from registered pend vectors.
- Best-case data path: `snoop_start` at cycle 0, CR handshake at cycle 1, CD beats at cycles 2–5, `data_rdy` at cycle 6, beats at cycles 7–10, `busy` low at cycle 11.
- Best-case no-data path: `snoop_start` at cycle 0, CR at cycle 1, `no_data` at cycle 2, IDLE at cycle 3.
- Downstream captures on the 4 cycles following `data_rdy`; this timing is mandatory.

## Test plan
- Mask 8'b0000_0110; both masters return CRRESP 5'b01000 (IsShared, no data) at cycle 1 → `no_data` at cycle 2, `crresp_out`=4'b1000, `cache_line_out` stays 0.
- Mask 8'b0000_0100; master 2 returns CRRESP 5'b00101, then beats 0xA0..0xA3 with `CDLAST` on the 4th → `data_rdy` at cycle 6; `cache_line_out`=0xA0,0xA1,0xA2,0xA3 at cycles 7–10; `crresp_out`=4'b0100.
- Masters 1 and 3 both return DataTransfer in the same cycle, master 3 streaming 0xB*, master 1 streaming 0xC* concurrently → master 1 is selected, output is 0xC0..0xC3, and both masters see `CDREADY` until their `CDLAST`.
- Selected master asserts `CDLAST` on beat 2 → `crresp_out`[1:0]=2'b10, beat 3 output is 0, `data_rdy` is still issued.
- `snoop_mask`=0 → `no_data` the cycle after `snoop_start`, `crresp_out`=0.
- `ARESET` asserted during CD_COLLECT → next cycle: IDLE, all outputs 0, no `data_rdy`; a new transaction then completes normally.
